mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter REQUESTERS, default 2, number of bus requesters (legal 2..4).
REQ-002 SHALL have parameter LOCK_MAX, default 4, maximum consecutive locked grants to one requester.
REQ-003 SHALL have port aClock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port aReset  input  1  reset, asynchronous, active-low (0 = reset).
REQ-005 SHALL have port aReq  input  [REQUESTERS-1:0]  per-requester access request.
REQ-006 SHALL have port aLock  input  [REQUESTERS-1:0]  request to keep the bus for the next access (read-modify-write).
REQ-007 SHALL have port aAddress  input  [REQUESTERS-1:0][15:0]  per-requester word address.
REQ-008 SHALL have port aWrite  input  [REQUESTERS-1:0]  1 = write, 0 = read.
REQ-009 SHALL have port aWriteData  input  [REQUESTERS-1:0][15:0]  per-requester write data.
REQ-010 SHALL have port anOutGrant  output  [REQUESTERS-1:0]  one-hot, one-cycle pulse: request captured.
REQ-011 SHALL have port anOutValid  output  [REQUESTERS-1:0]  one-hot, one-cycle pulse: access complete (read data valid, or write done).
REQ-012 SHALL have port anOutReadData  output  16  read data, valid only with anOutValid.
REQ-013 SHALL have port anOutAddress  output  16  memory address.
REQ-014 SHALL have port anOutData  output  16  memory write data.
REQ-015 SHALL have port anOutWrite  output  1  memory write strobe.
REQ-016 SHALL have port aData  input  16  memory read data, valid one cycle after address is driven.

Function
REQ-017 SHALL implement states IDLE, ACCESS, RESPOND; each ACCESS lasts exactly one cycle.
REQ-018 SHALL arbitrate in IDLE and in RESPOND: on the edge where any aReq is high, capture winner's address/write/data, go to ACCESS, else go to IDLE.
REQ-019 SHALL pulse anOutGrant[winner] in the ACCESS cycle and drive anOutAddress/anOutData/anOutWrite from the captured request in that cycle only; anOutWrite = 0 in all other cycles.
REQ-020 SHALL, in RESPOND (cycle after ACCESS), pulse anOutValid[winner] and present anOutReadData = aData (for writes anOutReadData is don't-care).
REQ-021 SHALL give latency aReq sampled at edge k -> grant in cycle k+1 -> valid in cycle k+2; back-to-back throughput one access per 2 cycles.
REQ-022 SHALL choose the winner round-robin: search from (last granted + 1) modulo REQUESTERS, wrapping; pointer updates to each winner.
REQ-023 SHALL ignore aReq in ACCESS cycles; a request dropped before an arbitration edge produces no access.
REQ-024 SHALL, if the current winner has aReq and aLock high at the RESPOND arbitration edge, grant it again regardless of rotation, while its consecutive-lock count < LOCK_MAX.
REQ-025 SHALL, when the lock count reaches LOCK_MAX, ignore aLock for that edge and apply normal round-robin; count clears on any non-locked grant.
REQ-026 SHALL keep anOutAddress and anOutData at their last values outside ACCESS (no requirement to zero them).

Reset
REQ-027 SHALL, on aReset = 0, immediately set state IDLE, round-robin pointer REQUESTERS-1 (requester 0 wins first), lock count 0, all outputs 0.
REQ-028 SHALL abort any in-flight access on reset: no anOutValid is issued for it; anOutWrite falls asynchronously.
REQ-029 SHALL begin arbitration on the first rising edge after aReset returns to 1.

Structure
REQ-030 SHALL place the ArbState enum, a BusRequest packed struct (address, data, write) and the 16-bit word width constant in shared package risc16_bus_pkg.
REQ-031 SHALL implement the round-robin search as combinational sub-module rr_priority_pick (inputs request vector and pointer, output one-hot winner).

Verification
REQ-032 SHALL test reset priority: release reset, aReq = 2'b11 -> grant 2'b01 at k+1, grant 2'b10 at k+3, valid follows each by one cycle.
REQ-033 SHALL test read: requester 1 reads 0x0400, memory returns 0xBEEF -> anOutValid = 2'b10 and anOutReadData = 0xBEEF at k+2.
REQ-034 SHALL test write: requester 0 writes 0x1234 to 0x0010 -> anOutWrite high exactly one cycle with anOutAddress 0x0010, anOutData 0x1234.
REQ-035 SHALL test lock: requester 0 holds aReq and aLock, requester 1 requests -> requester 0 wins 1 + LOCK_MAX = 5 consecutive grants, then requester 1 wins.
REQ-036 SHALL test mid-access reset: assert aReset = 0 during ACCESS of a write -> anOutWrite drops immediately, no anOutValid, requester 0 wins first after release.

Source files
------------

// File: rtl/risc16_bus_pkg.sv
// Shared bus definitions for the 16-bit memory arbiter.
//   WORD_W     : data/address word width
//   ArbState   : arbiter sequencing states
//   BusRequest : one captured requester access (address, write data, direction)
package risc16_bus_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } ArbState;

  typedef struct packed {
    logic [WORD_W-1:0] address;
    logic [WORD_W-1:0] data;
    logic              write;
  } BusRequest;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker.
//   req       : request vector, one bit per requester
//   ptr       : index of the most recently granted requester
//   grant     : one-hot winner, searching from ptr+1 upward and wrapping
//   grant_idx : binary index of the winner (0 when nothing is requested)
//   any_req   : at least one request is present
module rr_priority_pick #(
  parameter  int N     = 2,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_req
);

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    logic found;
    int   idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    // The last winner (offset N) is checked last, so it only wins when
    // nobody else is asking.
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous 16-bit memory port among
// REQUESTERS bus masters, with bounded read-modify-write locking.
//   aClock / aReset         : clock, asynchronous active-low reset
//   aReq, aLock             : per-requester request and keep-the-bus hint
//   aAddress, aWrite,
//   aWriteData              : per-requester access description
//   anOutGrant              : one-hot pulse in the ACCESS cycle
//   anOutValid              : one-hot pulse in the RESPOND cycle
//   anOutReadData           : memory read data, meaningful with anOutValid
//   anOutAddress, anOutData,
//   anOutWrite              : memory port (address/data hold between accesses)
//   aData                   : memory read data, one cycle after the address
module mem_arbiter
  import risc16_bus_pkg::*;
#(
  parameter int REQUESTERS = 2,
  parameter int LOCK_MAX   = 4
) (
  input  logic                               aClock,
  input  logic                               aReset,
  input  logic [REQUESTERS-1:0]              aReq,
  input  logic [REQUESTERS-1:0]              aLock,
  input  logic [REQUESTERS-1:0][WORD_W-1:0]  aAddress,
  input  logic [REQUESTERS-1:0]              aWrite,
  input  logic [REQUESTERS-1:0][WORD_W-1:0]  aWriteData,
  output logic [REQUESTERS-1:0]              anOutGrant,
  output logic [REQUESTERS-1:0]              anOutValid,
  output logic [WORD_W-1:0]                  anOutReadData,
  output logic [WORD_W-1:0]                  anOutAddress,
  output logic [WORD_W-1:0]                  anOutData,
  output logic                               anOutWrite,
  input  logic [WORD_W-1:0]                  aData
);

  localparam int PTR_W = $clog2(REQUESTERS);
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  ArbState               state_q,    state_d;
  logic [PTR_W-1:0]      ptr_q,      ptr_d;
  logic [CNT_W-1:0]      lock_cnt_q, lock_cnt_d;
  logic [REQUESTERS-1:0] winner_q,   winner_d;
  BusRequest             req_q,      req_d;

  logic [REQUESTERS-1:0] rr_grant;
  logic [PTR_W-1:0]      rr_idx;
  logic                  any_req;
  logic                  lock_hold;

  rr_priority_pick #(
    .N (REQUESTERS)
  ) u_pick (
    .req       (aReq),
    .ptr       (ptr_q),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .any_req   (any_req)
  );

  // ptr_q always names the requester served by the access now responding,
  // so a locked re-grant simply keeps the pointer where it is.
  assign lock_hold = (state_q == RESPOND) && aReq[ptr_q] && aLock[ptr_q] &&
                     (lock_cnt_q < CNT_W'(LOCK_MAX));

  always_comb begin
    logic [PTR_W-1:0] sel;
    state_d    = state_q;
    ptr_d      = ptr_q;
    lock_cnt_d = lock_cnt_q;
    winner_d   = winner_q;
    req_d      = req_q;
    sel        = rr_idx;

    unique case (state_q)
      ACCESS: state_d = RESPOND;
      IDLE, RESPOND: begin
        if (any_req) begin
          if (lock_hold) begin
            sel        = ptr_q;
            winner_d   = winner_q;
            lock_cnt_d = lock_cnt_q + CNT_W'(1);
          end else begin
            sel        = rr_idx;
            winner_d   = rr_grant;
            lock_cnt_d = '0;
          end
          state_d       = ACCESS;
          ptr_d         = sel;
          req_d.address = aAddress[sel];
          req_d.data    = aWriteData[sel];
          req_d.write   = aWrite[sel];
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge aClock or negedge aReset) begin
    if (!aReset) begin
      state_q    <= IDLE;
      ptr_q      <= PTR_W'(REQUESTERS - 1);
      lock_cnt_q <= '0;
      winner_q   <= '0;
      req_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lock_cnt_q <= lock_cnt_d;
      winner_q   <= winner_d;
      req_q      <= req_d;
    end
  end

  // Strobes decode from state_q, so an asynchronous reset drops them at once
  // and an aborted access never reaches RESPOND.
  assign anOutGrant    = (state_q == ACCESS)  ? winner_q : '0;
  assign anOutValid    = (state_q == RESPOND) ? winner_q : '0;
  assign anOutWrite    = (state_q == ACCESS) && req_q.write;
  assign anOutReadData = (state_q == RESPOND) ? aData : '0;
  // req_q only loads at a capture edge, so address/data hold between accesses.
  assign anOutAddress  = req_q.address;
  assign anOutData     = req_q.data;

endmodule
